// File: rtl/bin_search_ctrl.sv
// bin_search_ctrl: binary-search initiator for the magnitude-comparator family.
// Drives a guess on comparator A, consumes the one-hot relation code and
// narrows [lo, hi] until the comparator reports equality.
// Optional feature: define BSRCH_TIMEOUT_EN to add a 4-bit stall watchdog
// that ends the search with error after 15 consecutive stalled cycles.
module bin_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [WIDTH-1:0]              guess,
  output logic                          guess_valid,
  input  logic [2:0]                    cmp_result,
  input  logic                          cmp_valid,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              found,
  output logic                          error,
  output logic [$clog2(WIDTH+2)-1:0]    steps
);

  localparam int STEPS_W = $clog2(WIDTH+2);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo, hi, mid;
  logic             accept;
  logic             fin_ok, fin_err;
  logic             narrow_hi, narrow_lo;

`ifdef BSRCH_TIMEOUT_EN
  logic [3:0]       wdog;
`endif

  // Midpoint of the current range; the sum needs one extra bit so that
  // lo + hi near the top of the range does not wrap.
  function automatic logic [WIDTH-1:0] calc_mid(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  assign mid         = calc_mid(lo, hi);
  assign guess_valid = (state == SEARCH);
  assign busy        = (state == SEARCH);
  assign done        = (state == DONE);
  assign guess       = (state == SEARCH) ? mid : '0;
  assign accept      = (state == SEARCH) && cmp_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and result decode; range guards turn an inconsistent
  // responder into an error instead of letting lo/hi wrap.
  always_comb begin
    state_nxt = state;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    narrow_hi = 1'b0;
    narrow_lo = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (cmp_valid) begin
          case (cmp_result)
            3'b001: fin_ok = 1'b1;
            3'b100: begin
              if (mid == lo) fin_err   = 1'b1;
              else           narrow_hi = 1'b1;
            end
            3'b010: begin
              if (mid == hi) fin_err   = 1'b1;
              else           narrow_lo = 1'b1;
            end
            default: fin_err = 1'b1;
          endcase
        end
`ifdef BSRCH_TIMEOUT_EN
        else if (wdog == 4'd14) begin
          // This is the 15th consecutive stalled cycle.
          fin_err = 1'b1;
        end
`endif
        if (fin_ok || fin_err) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Search range, result registers and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo    <= '0;
      hi    <= '1;
      found <= '0;
      error <= 1'b0;
      steps <= '0;
`ifdef BSRCH_TIMEOUT_EN
      wdog  <= '0;
`endif
    end else if ((state == IDLE) && start) begin
      lo    <= '0;
      hi    <= '1;
      found <= '0;
      error <= 1'b0;
      steps <= '0;
`ifdef BSRCH_TIMEOUT_EN
      wdog  <= '0;
`endif
    end else if (accept) begin
      steps <= steps + STEPS_W'(1);
`ifdef BSRCH_TIMEOUT_EN
      wdog  <= '0;
`endif
      if (fin_ok)    found <= mid;
      if (fin_err)   error <= 1'b1;
      if (narrow_hi) hi    <= mid - WIDTH'(1);
      if (narrow_lo) lo    <= mid + WIDTH'(1);
    end
`ifdef BSRCH_TIMEOUT_EN
    else if (state == SEARCH) begin
      wdog <= wdog + 4'd1;
      if (fin_err) error <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Testbench for bin_search_ctrl (WIDTH=4): table of directed searches,
// randomized searches against a behavioural binary-search model, and
// hand-written reset / stall sequences.
module tb_bin_search_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] guess;
  logic         guess_valid;
  logic [2:0]   cmp_result;
  logic         cmp_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] found;
  logic         error;
  logic [$clog2(W+2)-1:0] steps;

  // Responder configuration.
  int hid;
  int rmode;     // 0 honest, 1 always 010, 2 always 100, 3 invalid 011
  int stall_n;   // cycles cmp_valid stays low per guess
  bit hold_off;  // never answer
  int stall_cnt;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  int got_q[$];

  bin_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
    .guess_valid(guess_valid), .cmp_result(cmp_result), .cmp_valid(cmp_valid),
    .busy(busy), .done(done), .found(found), .error(error), .steps(steps)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] respond(input int g, input int h, input int m);
    case (m)
      0: begin
        if (g > h)      return 3'b100;
        else if (g < h) return 3'b010;
        else            return 3'b001;
      end
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  always_comb cmp_result = respond(int'(guess), hid, rmode);
  assign cmp_valid = guess_valid && !hold_off && (stall_cnt >= stall_n);

  always @(posedge clk) begin
    if (!guess_valid || cmp_valid) stall_cnt <= 0;
    else                           stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer binary search over [0, 2^W-1].
  task automatic model(input int h, input int m,
                       output int efound, output int eerr, output int esteps);
    int lo, hi, mid;
    logic [2:0] code;
    lo = 0; hi = (1 << W) - 1;
    efound = 0; eerr = 0; esteps = 0;
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      mid = (lo + hi) / 2;
      exp_q.push_back(mid);
      esteps++;
      code = respond(mid, h, m);
      if (code == 3'b001) begin efound = mid; break; end
      else if (code == 3'b100) begin
        if (mid == lo) begin eerr = 1; break; end
        hi = mid - 1;
      end else if (code == 3'b010) begin
        if (mid == hi) begin eerr = 1; break; end
        lo = mid + 1;
      end else begin eerr = 1; break; end
    end
  endtask

  // One full search; exp_lat < 0 means derive latency from steps and stall.
  task automatic run(input string tag, input int h, input int m, input int stl,
                     input bit inj_start, input int exp_lat);
    int efound, eerr, esteps, cyc, lat;
    bit seen, stab_bad, pstall;
    logic [W-1:0] pg;
    model(h, m, efound, eerr, esteps);
    lat = (exp_lat < 0) ? esteps * (stl + 1) + 1 : exp_lat;
    hid = h; rmode = m; stall_n = stl;
    got_q.delete();
    seen = 0; stab_bad = 0; pstall = 0; pg = '0; cyc = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = inj_start && (cyc == 2);
      if (guess_valid && cmp_valid) got_q.push_back(int'(guess));
      if (pstall && guess_valid && guess !== pg) stab_bad = 1;
      pstall = guess_valid && !cmp_valid;
      pg = guess;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".found"}, found, efound);
    chk({tag, ".error"}, error, eerr);
    chk({tag, ".steps"}, steps, esteps);
    chk({tag, ".guess_stable"}, stab_bad, 0);
    chk({tag, ".n_guesses"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.guess%0d", tag, i), got_q[i], exp_q[i]);
    @(negedge clk);
    chk({tag, ".done_one_pulse"}, done, 0);
    chk({tag, ".found_hold"}, found, efound);
    chk({tag, ".steps_hold"}, steps, esteps);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".guess"}, guess, 0);
    chk({tag, ".guess_valid"}, guess_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".found"}, found, 0);
    chk({tag, ".error"}, error, 0);
    chk({tag, ".steps"}, steps, 0);
  endtask

  typedef struct {
    int h; int m; int stl; bit inj; int lat;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   nd;
    bit   got_done;
    vecs[0] = '{h:11, m:0, stl:0, inj:0, lat:3};
    vecs[1] = '{h:0,  m:0, stl:0, inj:0, lat:5};
    vecs[2] = '{h:15, m:0, stl:0, inj:0, lat:6};
    vecs[3] = '{h:0,  m:1, stl:0, inj:0, lat:6};
    vecs[4] = '{h:0,  m:2, stl:0, inj:0, lat:5};
    vecs[5] = '{h:5,  m:0, stl:3, inj:1, lat:13};
    vecs[6] = '{h:0,  m:3, stl:0, inj:0, lat:2};

    rst_n = 1'b0; start = 1'b0; hid = 0; rmode = 0; stall_n = 0; hold_off = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_active");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_released");

    foreach (vecs[i])
      run($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].stl,
          vecs[i].inj, vecs[i].lat);

    for (int r = 0; r < 20; r++)
      run($sformatf("rnd%0d", r), int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
          int'($urandom_range(0, 3)), 1'b0, -1);

    // Reset mid-search after one result has been accepted.
    hid = 5; rmode = 0; stall_n = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst.busy_before", busy, 1);
    chk("midrst.steps_before", steps, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst.no_done", nd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.idle_after", busy, 0);

    // Responder never answers.
    hold_off = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
`ifdef BSRCH_TIMEOUT_EN
    chk("stall.timeout_done", got_done, 1);
    chk("stall.timeout_error", error, 1);
    chk("stall.timeout_steps", steps, 0);
`else
    chk("stall.no_done", got_done, 0);
    chk("stall.busy_held", busy, 1);
    chk("stall.guess_held", guess, 7);
`endif
    hold_off = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
